aclk_timebase_gen: RTL
======================

Name: aclk_timebase_gen

Overview:
Parametrised timebase for the alarm clock. It divides the system clock into single-cycle one_second, one_minute and one_hour strobes and exposes the running second/minute counts. A fast_watch mode advances minutes once per second for demo and test. It feeds the clock counter, alarm comparator and display blocks.

Parameters:
CLKS_PER_SEC, 256, clk cycles per second; must be >= 2
SECS_PER_MIN, 60, seconds per minute; must be >= 2
MINS_PER_HOUR, 60, minutes per hour; must be >= 2
PRE_W, $clog2(CLKS_PER_SEC), prescaler width (derived, not overridden)
SEC_W, $clog2(SECS_PER_MIN), sec_count width (derived)
MIN_W, $clog2(MINS_PER_HOUR), min_count width (derived)
TRIM_W, 4, width of the signed trim input (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
reset_count  in  1  synchronous clear of all counters and strobes
enable  in  1  count enable; low = freeze, all strobes low
fast_watch  in  1  1 = minute strobe on every second strobe
one_second  out  1  single-cycle second strobe
one_minute  out  1  single-cycle minute strobe
one_hour  out  1  single-cycle hour strobe
sec_count  out  SEC_W  current second, 0..SECS_PER_MIN-1
min_count  out  MIN_W  current minute, 0..MINS_PER_HOUR-1

Behaviour:
- Reset is asynchronous, active-high, on clock clk. On reset all counters are 0 and all outputs are 0.
- All outputs are registered. There is no combinational input-to-output path.
- Priority order at each posedge: reset_count, then enable, then normal counting.
- reset_count=1: prescaler, sec_count and min_count go to 0 and all strobes go low on that edge. This takes effect even when enable=0.
- enable=0: counters hold and strobes are driven 0 on that edge. A strobe that was pending is lost, not deferred.
- Prescaler: when enable=1 it counts 0..CLKS_PER_SEC-1 and wraps. At the wrap edge one_second is set to 1 for exactly one cycle. With enable held high, one_second occurs every CLKS_PER_SEC cycles. The first one_second is high in cycle CLKS_PER_SEC after reset release.
- Seconds: sec_count increments on each second tick, which is the same edge that sets one_second. It wraps from SECS_PER_MIN-1 to 0.
- Minute event in normal mode (fast_watch=0): the second tick on which sec_count wraps. one_minute is coincident with that one_second.
- Minute event in fast mode (fast_watch=1): every second tick. sec_count keeps counting normally.
- fast_watch is sampled at the tick edge. Toggling it between ticks is glitch-free and causes no extra or lost minute beyond the mode rule.
- min_count increments on each minute event and wraps from MINS_PER_HOUR-1 to 0. one_hour is asserted on the minute event that wraps min_count, coincident with one_minute.
- Simultaneous strobes are allowed: one_second, one_minute and one_hour may all be 1 in the same cycle.

Optional Feature:
ACLK_TIMEBASE_TRIM_EN:
- Defined: adds input port trim (signed, TRIM_W bits).
- trim is sampled at each prescaler wrap. The next second lasts CLKS_PER_SEC+trim cycles, clamped to a minimum of 2.
- PRE_W is widened by 1 to hold the longest second.
- Undefined: no trim port; every second is exactly CLKS_PER_SEC cycles.

Decomposition:
- Package aclk_pkg holds the default constants (ACLK_CLKS_PER_SEC, ACLK_SECS_PER_MIN, ACLK_MINS_PER_HOUR) and a width helper.
- One sub-module is natural: aclk_mod_counter, a parametrised modulo-N counter with enable, sync clear and wrap strobe.
- aclk_mod_counter is instantiated three times: prescaler, seconds and minutes.

Test Plan (CLKS_PER_SEC=4, SECS_PER_MIN=3, MINS_PER_HOUR=2):
- Reset release, enable=1 -> one_second at cycles 4, 8, 12; one_minute at cycle 12 only; one_hour at cycle 24 together with one_second and one_minute; sec_count sequence 1, 2, 0.
- fast_watch=1 from reset -> one_minute coincident with every one_second; one_hour at cycle 8; sec_count unchanged versus normal mode.
- enable=0 for 5 cycles at prescaler=2 -> no strobes while low; counts frozen; next one_second 2 cycles after enable returns.
- reset_count pulse with sec_count=2, min_count=1 -> both 0 on the next edge; next one_second 4 cycles later; a reset_count during a strobe cycle produces no strobe the following cycle.
- Async reset asserted mid-second, between edges -> all outputs 0 immediately, without waiting for a clock edge.
- With ACLK_TIMEBASE_TRIM_EN, trim=+2 -> second period 6 cycles; trim=-5 -> period clamps to 2.

Source files
------------

// File: rtl/aclk_timebase_gen_pkg.sv
// Shared constants and width helper for the alarm-clock timebase.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aclk_pkg;

    localparam int ACLK_CLKS_PER_SEC  = 256;
    localparam int ACLK_SECS_PER_MIN  = 60;
    localparam int ACLK_MINS_PER_HOUR = 60;

    // Counter width for a modulus n; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/aclk_timebase_gen_if.sv
// Control and status bundle between the timebase and its consumers.
// Latency: n/a (wires only).
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
interface aclk_timebase_gen_if
    import aclk_pkg::*;
#(
    parameter int SEC_W = cnt_w(ACLK_SECS_PER_MIN),
    parameter int MIN_W = cnt_w(ACLK_MINS_PER_HOUR)
);
    logic             reset_count;
    logic             enable;
    logic             fast_watch;
    logic             one_second;
    logic             one_minute;
    logic             one_hour;
    logic [SEC_W-1:0] sec_count;
    logic [MIN_W-1:0] min_count;

    // Consumer / controller side: drives the controls, observes the timebase.
    modport master (
        output reset_count, enable, fast_watch,
        input  one_second, one_minute, one_hour, sec_count, min_count
    );

    // Timebase side.
    modport slave (
        input  reset_count, enable, fast_watch,
        output one_second, one_minute, one_hour, sec_count, min_count
    );
endinterface

// File: rtl/aclk_timebase_gen_mod_counter.sv
// Modulo counter 0..last with enable, sync clear and a registered wrap strobe.
// Latency: count and strobe update on the enabled edge; strobe is high the cycle after.
// Backpressure: none; a disabled edge drops the strobe and holds the count.
module aclk_mod_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,        // synchronous clear, beats en
    input  logic         en,         // advance on this edge
    input  logic         stb_force,  // strobe on this step even without a wrap
    input  logic [W-1:0] last,       // terminal count (modulus - 1)
    output logic [W-1:0] count,
    output logic         stb
);

    logic at_last;

    // >= rather than == so a shrinking terminal count can never strand the counter.
    assign at_last = (count >= last);

    // Count, wrap to zero at the terminal value, pulse stb on wrap or forced step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            stb   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            stb   <= 1'b0;
        end else begin
            stb <= en && (at_last || stb_force);
            if (en) begin
                count <= at_last ? '0 : count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/aclk_timebase_gen.sv
// Alarm-clock timebase: second/minute/hour strobes plus running sec/min counts.
// Latency: all outputs registered; first one_second CLKS_PER_SEC cycles after reset.
// Backpressure: none; enable=0 freezes counts and drops strobes. Option: ACLK_TIMEBASE_TRIM_EN.
module aclk_timebase_gen
    import aclk_pkg::*;
#(
    parameter int CLKS_PER_SEC  = ACLK_CLKS_PER_SEC,
    parameter int SECS_PER_MIN  = ACLK_SECS_PER_MIN,
    parameter int MINS_PER_HOUR = ACLK_MINS_PER_HOUR
`ifdef ACLK_TIMEBASE_TRIM_EN
    ,
    parameter int TRIM_W        = 4
`endif
) (
    input logic                     clk,
    input logic                     reset,
`ifdef ACLK_TIMEBASE_TRIM_EN
    input logic signed [TRIM_W-1:0] trim,
`endif
    aclk_timebase_gen_if.slave      bus
);

    localparam int SEC_W = cnt_w(SECS_PER_MIN);
    localparam int MIN_W = cnt_w(MINS_PER_HOUR);
`ifdef ACLK_TIMEBASE_TRIM_EN
    // One spare bit so a positively trimmed second still fits.
    localparam int PRE_W = cnt_w(CLKS_PER_SEC) + 1;
`else
    localparam int PRE_W = cnt_w(CLKS_PER_SEC);
`endif

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SECS_PER_MIN - 1);
    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MINS_PER_HOUR - 1);
    localparam logic [PRE_W-1:0] PRE_DFLT = PRE_W'(CLKS_PER_SEC - 1);

    logic [PRE_W-1:0] pre_count;
    logic [PRE_W-1:0] pre_last;
    logic             sec_tick;
    logic             min_event;

    // A second tick is the enabled prescaler wrap edge.
    assign sec_tick  = bus.enable && (pre_count >= pre_last);
    // Minute event: seconds wrap in normal mode, every second tick in fast mode.
    assign min_event = sec_tick && ((bus.sec_count >= SEC_LAST) || bus.fast_watch);

`ifdef ACLK_TIMEBASE_TRIM_EN
    int trim_period;

    // Length of the next second: nominal plus signed trim, never shorter than 2.
    always_comb begin
        trim_period = CLKS_PER_SEC + int'(trim);
        if (trim_period < 2) begin
            trim_period = 2;
        end
    end

    // Latch the trimmed terminal count at each prescaler wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_last <= PRE_DFLT;
        end else if (bus.reset_count) begin
            pre_last <= PRE_DFLT;
        end else if (sec_tick) begin
            pre_last <= PRE_W'(trim_period - 1);
        end
    end
`else
    assign pre_last = PRE_DFLT;
`endif

    // Prescaler: its wrap strobe is one_second.
    aclk_mod_counter #(.W(PRE_W)) u_pre (
        .clk       (clk),
        .reset     (reset),
        .clr       (bus.reset_count),
        .en        (bus.enable),
        .stb_force (1'b0),
        .last      (pre_last),
        .count     (pre_count),
        .stb       (bus.one_second)
    );

    // Seconds: forcing the strobe in fast mode turns its wrap strobe into one_minute.
    aclk_mod_counter #(.W(SEC_W)) u_sec (
        .clk       (clk),
        .reset     (reset),
        .clr       (bus.reset_count),
        .en        (sec_tick),
        .stb_force (bus.fast_watch),
        .last      (SEC_LAST),
        .count     (bus.sec_count),
        .stb       (bus.one_minute)
    );

    // Minutes: advances on each minute event; its wrap strobe is one_hour.
    aclk_mod_counter #(.W(MIN_W)) u_min (
        .clk       (clk),
        .reset     (reset),
        .clr       (bus.reset_count),
        .en        (min_event),
        .stb_force (1'b0),
        .last      (MIN_LAST),
        .count     (bus.min_count),
        .stb       (bus.one_hour)
    );

endmodule
